// File: rtl/round_key_store.sv
// Round key register file: captures the expanded key schedule once and
// replays it forward (encrypt) or reverse (decrypt) over a valid/ready stream.
`timescale 1ns/1ps
module round_key_store #(
    parameter int KEY_S = 128,
    parameter int NR    = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             w_e,
    input  logic [3:0]       round_no,
    input  logic [0:KEY_S-1] round_key,
    input  logic             key_done,
    input  logic             rd_start,
    input  logic             rd_dir,
    output logic [0:KEY_S-1] key_o,
    output logic [3:0]       key_round,
    output logic             key_valid,
    input  logic             key_ready,
    output logic             key_last,
    output logic             keys_valid,
    output logic             busy
);

    localparam logic [3:0] LAST = 4'(NR);

    typedef enum logic [1:0] {
        IDLE,
        READY,
        READING
    } state_t;

    state_t           state_q, state_d;
    logic [NR:0]      mask_q, mask_d;
    logic [0:KEY_S-1] mem_q [0:NR];
    logic [0:KEY_S-1] key_q, key_d;
    logic [3:0]       rnd_q, rnd_d;
    logic             dir_q, dir_d;

    logic wr_ok;
    logic abort;
    logic start;
    logic xfer;
    logic last;
    logic full;

    assign wr_ok = w_e && (round_no <= LAST);
    assign abort = w_e && (round_no == 4'd0);
    assign start = (state_q == READY) && rd_start && !w_e;
    assign xfer  = (state_q == READING) && key_ready;
    assign last  = (state_q == READING)
                && (dir_q ? (rnd_q == 4'd0) : (rnd_q == LAST));
    assign full  = &mask_d;

    // Storage has no reset; the mask alone tracks which entries are live.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem_q[round_no] <= round_key;
        end
    end

    always_comb begin
        mask_d = mask_q;
        if (abort) begin
            mask_d = {{NR{1'b0}}, 1'b1};
        end else if (wr_ok) begin
            mask_d[round_no] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            mask_q  <= '0;
            key_q   <= '0;
            rnd_q   <= '0;
            dir_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            key_q   <= key_d;
            rnd_q   <= rnd_d;
            dir_q   <= dir_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE:    if (key_done && full) state_d = READY;
                READY:   if (start) state_d = READING;
                READING: if (xfer && last) state_d = READY;
                default: state_d = IDLE;
            endcase
        end
    end

    // Pointer doubles as key_round; the key is fetched for the next index.
    always_comb begin
        key_d = key_q;
        rnd_d = rnd_q;
        dir_d = dir_q;
        if (start) begin
            dir_d = rd_dir;
            rnd_d = rd_dir ? LAST : 4'd0;
            key_d = mem_q[rnd_d];
        end else if (xfer && !last && !abort) begin
            rnd_d = dir_q ? (rnd_q - 4'd1) : (rnd_q + 4'd1);
            key_d = mem_q[rnd_d];
        end
    end

    always_comb begin
        busy       = (state_q == READING);
        key_valid  = (state_q == READING);
        keys_valid = (state_q != IDLE);
        key_last   = last;
        key_o      = key_q;
        key_round  = rnd_q;
    end

endmodule

// File: tb/tb_round_key_store.sv
// Scoreboard bench for round_key_store: driver pushes expected replays,
// a negedge monitor pops and compares on every accepted key.
`timescale 1ns/1ps
module tb_round_key_store;

    logic         clk = 1'b0;
    logic         reset, w_e, key_done, rd_start, rd_dir, key_ready;
    logic [3:0]   round_no, key_round;
    logic [127:0] round_key, key_o;
    logic         key_valid, key_last, keys_valid, busy;

    always #5 clk = ~clk;

    round_key_store #(.KEY_S(128), .NR(10)) dut (
        .clk(clk), .reset(reset), .w_e(w_e), .round_no(round_no),
        .round_key(round_key), .key_done(key_done), .rd_start(rd_start),
        .rd_dir(rd_dir), .key_o(key_o), .key_round(key_round),
        .key_valid(key_valid), .key_ready(key_ready), .key_last(key_last),
        .keys_valid(keys_valid), .busy(busy)
    );

    localparam logic [127:0] FIPS [11] = '{
        128'h2b7e151628aed2a6abf7158809cf4f3c,
        128'ha0fafe1788542cb123a339392a6c7605,
        128'hf2c295f27a96b9435935807a7359f67f,
        128'h3d80477d4716fe3e1e237e446d7a883b,
        128'hef44a541a8525b7fb671253bdb0bad00,
        128'hd4d1c6f87c839d87caf2b8bc11f915bc,
        128'h6d88a37a110b3efddbf98641ca0093fd,
        128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
        128'head27321b58dbad2312bf5607f8d292f,
        128'hac7766f319fadc2128d12941575c006e,
        128'hd014f9a8c9ee2589e13f0cc8b6630ca6
    };

    typedef struct {
        logic [127:0] k;
        logic [3:0]   r;
        logic         l;
    } exp_t;

    exp_t         exp_q [$];
    int           vectors = 0;
    int           miscompares = 0;
    logic [127:0] ref_mem [11];
    logic [10:0]  ref_mask;
    bit           ref_kv;
    bit           ref_busy;
    bit           acc;

    task automatic check(input string name, input logic [127:0] act,
                         input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Monitor: compare every accepted key, and hold-stability while stalled.
    exp_t         mon_e;
    logic         stalled = 1'b0;
    logic [127:0] st_k;
    logic [3:0]   st_r;
    logic         st_l;

    always @(negedge clk) begin
        if (key_valid === 1'b1) begin
            if (stalled) begin
                check("stall_key", key_o, st_k);
                check("stall_round", 128'(key_round), 128'(st_r));
                check("stall_last", 128'(key_last), 128'(st_l));
            end
            if (key_ready) begin
                stalled = 1'b0;
                if (exp_q.size() == 0) begin
                    check("unexpected_key", 128'(key_round), 128'hx);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("key_o", key_o, mon_e.k);
                    check("key_round", 128'(key_round), 128'(mon_e.r));
                    check("key_last", 128'(key_last), 128'(mon_e.l));
                end
            end else begin
                stalled = 1'b1;
                st_k = key_o;
                st_r = key_round;
                st_l = key_last;
            end
        end else begin
            stalled = 1'b0;
        end
    end

    task automatic wr(input int idx, input logic [127:0] k, input bit done);
        w_e = 1'b1;
        round_no = 4'(idx);
        round_key = k;
        key_done = done;
        cyc();
        w_e = 1'b0;
        key_done = 1'b0;
        if (idx <= 10) begin
            ref_mem[idx] = k;
            if (idx == 0) begin
                ref_mask = 11'b1;
                ref_kv = 1'b0;
                ref_busy = 1'b0;
                exp_q.delete();
            end else begin
                ref_mask[idx] = 1'b1;
            end
        end
        if (done) ref_kv = ref_kv || (ref_mask == 11'h7ff);
    endtask

    task automatic try_start(input bit dir, output bit ok);
        exp_t e;
        rd_start = 1'b1;
        rd_dir = dir;
        ok = ref_kv && !ref_busy;
        if (ok) begin
            for (int i = 0; i <= 10; i++) begin
                int idx;
                idx = dir ? 10 - i : i;
                e.k = ref_mem[idx];
                e.r = 4'(idx);
                e.l = (i == 10);
                exp_q.push_back(e);
            end
            ref_busy = 1'b1;
        end
        cyc();
        rd_start = 1'b0;
        check("busy_after_start", 128'(busy), 128'(ok));
        check("valid_after_start", 128'(key_valid), 128'(ok));
    endtask

    task automatic quiet(input int n);
        for (int i = 0; i < n; i++) begin
            key_ready = 1'b1;
            cyc();
            check("no_valid", 128'(key_valid), 128'd0);
        end
        key_ready = 1'b0;
    endtask

    task automatic drain(input int mode);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            case (mode)
                0:       key_ready = 1'b1;
                1:       key_ready = (n % 3 == 0);
                default: key_ready = 1'($urandom_range(0, 1));
            endcase
            cyc();
            n++;
        end
        key_ready = 1'b0;
        check("drain_left", 128'(exp_q.size()), 128'd0);
        if (mode == 0) check("replay_cycles", 128'(n), 128'd11);
        check("busy_end", 128'(busy), 128'd0);
        check("valid_end", 128'(key_valid), 128'd0);
        check("keys_valid_end", 128'(keys_valid), 128'd1);
        ref_busy = 1'b0;
    endtask

    task automatic replay(input bit dir, input int mode);
        bit ok;
        try_start(dir, ok);
        if (ok) drain(mode);
    endtask

    task automatic load(input bit use_fips, input int skip, input bit try_rd);
        bit ok;
        for (int i = 0; i <= 10; i++) begin
            if (i != skip) wr(i, use_fips ? FIPS[i] : rand128(), i == 10);
            if (try_rd && i == 3) begin
                try_start(1'b0, ok);
                quiet(2);
            end
        end
        check("keys_valid_load", 128'(keys_valid), 128'(ref_kv));
    endtask

    initial begin
        reset = 1'b1;
        w_e = 1'b0;
        key_done = 1'b0;
        rd_start = 1'b0;
        rd_dir = 1'b0;
        key_ready = 1'b0;
        round_no = 4'd0;
        round_key = '0;
        ref_mask = '0;
        ref_kv = 1'b0;
        ref_busy = 1'b0;
        cyc();
        cyc();
        check("rst_key_o", key_o, 128'd0);
        check("rst_key_round", 128'(key_round), 128'd0);
        check("rst_key_valid", 128'(key_valid), 128'd0);
        check("rst_key_last", 128'(key_last), 128'd0);
        check("rst_keys_valid", 128'(keys_valid), 128'd0);
        check("rst_busy", 128'(busy), 128'd0);
        reset = 1'b0;
        cyc();

        try_start(1'b0, acc);
        quiet(3);

        load(1'b1, -1, 1'b1);
        check("fips_loaded", 128'(keys_valid), 128'd1);
        replay(1'b0, 0);
        replay(1'b1, 0);
        replay(1'b0, 1);

        for (int l = 0; l < 3; l++) begin
            load(1'b0, -1, 1'b0);
            for (int r = 0; r < 3; r++) replay(1'($urandom_range(0, 1)), 2);
        end

        load(1'b0, 5, 1'b0);
        check("hole_keys_valid", 128'(keys_valid), 128'd0);
        try_start(1'b1, acc);
        quiet(4);

        load(1'b1, -1, 1'b0);
        try_start(1'b0, acc);
        key_ready = 1'b1;
        cyc();
        cyc();
        cyc();
        wr(0, rand128(), 1'b0);
        check("abort_valid", 128'(key_valid), 128'd0);
        check("abort_busy", 128'(busy), 128'd0);
        check("abort_keys_valid", 128'(keys_valid), 128'd0);
        for (int i = 1; i <= 10; i++) begin
            wr(i, rand128(), i == 10);
            if (i == 9) check("reload_pending", 128'(keys_valid), 128'd0);
        end
        check("reload_done", 128'(keys_valid), 128'd1);
        replay(1'b0, 0);
        replay(1'b1, 2);

        try_start(1'b1, acc);
        key_ready = 1'b1;
        for (int i = 0; i < 4; i++) cyc();
        key_ready = 1'b0;
        cyc();
        check("stall_at_6", 128'(key_round), 128'd6);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        exp_q.delete();
        ref_mask = '0;
        ref_kv = 1'b0;
        ref_busy = 1'b0;
        check("mid_rst_key_o", key_o, 128'd0);
        check("mid_rst_round", 128'(key_round), 128'd0);
        check("mid_rst_valid", 128'(key_valid), 128'd0);
        check("mid_rst_last", 128'(key_last), 128'd0);
        check("mid_rst_keys_valid", 128'(keys_valid), 128'd0);
        check("mid_rst_busy", 128'(busy), 128'd0);
        try_start(1'b0, acc);
        quiet(3);
        load(1'b0, -1, 1'b0);
        replay(1'b1, 0);

        cyc();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/round_key_store.md
# round_key_store

Consumer side of the key-expansion write interface. It captures the 11 round keys streamed by the round key generator (`w_e`/`round_no`/`round_key`) into an internal register file. It then replays them to the AES datapath over a valid/ready stream, in forward order for encryption or reverse order for decryption. It sits between the key schedule and the cipher round engine, so keys are expanded once per key load and reused for every block.

## Interface
- `KEY_S`, 128, round key width in bits (matches `` `KEY_S ``)
- `NR`, 10, number of rounds; storage depth is `NR+1` (matches `` `Nr ``)

- `clk`  in  1  clock, rising edge
- `reset`  in  1  synchronous, active-high reset
- `w_e`  in  1  write strobe from key generator
- `round_no`  in  4  index of key on `round_key` (0..NR)
- `round_key`  in  [0:KEY_S-1]  round key data
- `key_done`  in  1  one-cycle pulse from generator marking the end of expansion; coincides with the write of index NR
- `rd_start`  in  1  one-cycle request to begin replay
- `rd_dir`  in  1  sampled with `rd_start`: 0 = forward (0..NR), 1 = reverse (NR..0)
- `key_o`  out  [0:KEY_S-1]  replayed round key
- `key_round`  out  4  index of `key_o`
- `key_valid`  out  1  `key_o`/`key_round`/`key_last` valid
- `key_ready`  in  1  downstream accepts the key
- `key_last`  out  1  final key of the replay
- `keys_valid`  out  1  complete key set stored
- `busy`  out  1  replay in progress

## Operation
- Reset values: `key_o` = 0, `key_round` = 0, `key_valid` = 0, `key_last` = 0, `keys_valid` = 0, `busy` = 0. The written-mask is cleared. Storage contents are don't-care.
- Write path:
  - `w_e`=1 with `round_no` ≤ NR stores `round_key` at `round_no` and sets that bit of an (NR+1)-bit written-mask.
  - `round_no` > NR is ignored.
  - A write with `round_no`=0 starts a new load. It clears the mask (except bit 0), clears `keys_valid`, and aborts any replay: `busy`, `key_valid` and `key_last` go to 0 next cycle.
- `key_done`: `keys_valid` is set the next cycle only if the mask, including the coincident write, is all ones. Otherwise `keys_valid` stays 0.
- States:
  - IDLE (`keys_valid`=0)
  - READY (`keys_valid`=1, `busy`=0)
  - READING (`busy`=1)
- Transitions:
  - READY + `rd_start` → READING. Pointer starts at 0 (`rd_dir`=0) or NR (`rd_dir`=1).
  - `rd_start` is ignored in IDLE, in READING, and in the same cycle as any write.
- READING behaviour:
  - `key_o`/`key_round` are registered from storage[pointer].
  - On a transfer (`key_valid` & `key_ready`), the pointer steps +1 (forward) or −1 (reverse) and the next key is presented.
  - `key_last` is 1 while `key_round` = NR (forward) or 0 (reverse).
  - A transfer with `key_last`=1 returns to READY: `key_valid`, `busy` and `key_last` = 0.
- While `key_valid`=1 and `key_ready`=0, `key_o`, `key_round` and `key_last` hold stable.
- Replay is repeatable any number of times without reloading.

## Timing
- `rd_start` at cycle t → `busy`=1 and `key_valid`=1 with the first key at t+1.
- Transfer at cycle t → next key on outputs at t+1. One key per cycle with `key_ready` held high; a full replay takes NR+1 = 11 cycles.
- Write at cycle t is readable by a replay started at t+1 or later.
- `key_done` at t → `keys_valid`=1 at t+1; `rd_start` is accepted from t+1.
- Load abort (write `round_no`=0) at t → `key_valid`=0 and `busy`=0 at t+1, even mid-handshake.
- Reset asserted mid-replay → all outputs at reset values on the next edge.

## Test plan
- Load FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c through the generator, then forward replay with `key_ready`=1 → 11 consecutive keys with `key_round` 0..10. Key 0 = 2b7e1516…09cf4f3c, key 10 = d014f9a8c9ee2589e13f0cc8b6630ca6, `key_last` only on key 10.
- Same load, reverse replay → first key d014f9a8…b6630ca6 with `key_round`=10, last key 2b7e1516…09cf4f3c with `key_last`=1. `busy` drops the cycle after.
- Forward replay with `key_ready` toggled 1,0,0,1,… → no key lost or duplicated, and outputs stable while stalled.
- `rd_start` before `key_done`, and `key_done` with index 5 never written → `keys_valid`=0, `key_valid` never asserts.
- Write with `round_no`=0 at the 4th transfer of a replay → `key_valid`=0 and `busy`=0 the next cycle, `keys_valid`=0 until the reload completes.
- Reset during reverse replay at `key_round`=6 → all outputs 0 next cycle, and `rd_start` is ignored until a new full load.
